ysyx_22050039_mem_responder: RTL

Single-outstanding data-memory responder that serves the load/store requests issued by the core's execute stage. It accepts one request per valid/ready handshake, holds it for a fixed latency, performs the byte-masked write or aligned read on an internal 64-bit word array, and returns one response per valid/ready handshake. It replaces the zero-latency DPI memory path with a synthesizable, stallable slave, so the execute side can be exercised against real handshake timing.

---
 rtl/ysyx_22050039_mem_responder_if.sv | 26 ++
 rtl/ysyx_22050039_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_mem_responder_if.sv
// Request/response handshake bundle between the execute stage (master)
// and the data-memory responder (slave).
interface ysyx_22050039_mem_responder_if #(
    parameter int XLEN = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22050039_mem_responder.sv
// Single-outstanding, fixed-latency data-memory responder over a 64-bit word array.
// Define MEMRSP_OOR_ERR_EN to flag and suppress out-of-range accesses (otherwise the index wraps).
module ysyx_22050039_mem_responder #(
    parameter int              XLEN    = 64,
    parameter int              DEPTH   = 1024,
    parameter logic [XLEN-1:0] BASE    = 64'h8000_0000,
    parameter int              LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22050039_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0] CNT_INIT = 4'(LAT_M1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            wen_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [NB-1:0]   wmask_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            enter_resp;
    logic            op_wen;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_wdata;
    logic [NB-1:0]   op_wmask;
    logic [XLEN-1:0] op_offset;
    logic [AW-1:0]   op_idx;
    logic            in_range;
    logic            do_write;
    logic            unused_bits;

    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign enter_resp    = !rst && ((state == S_WAIT && cnt == 4'd0) || (accept && LATENCY == 0));

    // With zero latency the access happens on the acceptance edge, so take the
    // operands straight from the bus while idle instead of from the latches.
    assign op_wen    = (state == S_IDLE) ? bus.req_wen   : wen_q;
    assign op_addr   = (state == S_IDLE) ? bus.req_addr  : addr_q;
    assign op_wdata  = (state == S_IDLE) ? bus.req_wdata : wdata_q;
    assign op_wmask  = (state == S_IDLE) ? bus.req_wmask : wmask_q;
    assign op_offset = op_addr - BASE;
    assign op_idx    = op_offset[3 +: AW];

`ifdef MEMRSP_OOR_ERR_EN
    logic resp_err_q;
    assign in_range     = (op_addr >= BASE) && (op_offset[XLEN-1:3+AW] == '0);
    assign bus.resp_err = resp_err_q;
`else
    assign in_range     = 1'b1;
    assign bus.resp_err = 1'b0;
`endif

    assign unused_bits    = ^{op_offset[XLEN-1:3+AW], op_offset[2:0]};
    assign do_write       = enter_resp && op_wen && in_range;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;

    // NOTE: the word array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (op_wmask[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef MEMRSP_OOR_ERR_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wen_q   <= bus.req_wen;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wmask_q <= bus.req_wmask;
                        if (LATENCY > 0) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (resp_valid_q && bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (op_wen || !in_range) ? '0 : mem[op_idx];
`ifdef MEMRSP_OOR_ERR_EN
                resp_err_q   <= !in_range;
`endif
            end
        end
    end
endmodule
